// File: rtl/barker_pkg.sv
// Shared definitions for the 11-bit Barker transmitter and correlator.
// Holds the sequence length, the sequence itself, the transmitter state
// encoding, the command word layout and a helper that returns one frame bit.
package barker_pkg;

    localparam int          BARKER_LEN = 11;
    localparam logic [10:0] BARKER11   = 11'b11100010010;

    // Index of the first (most significant) bit sent in a frame.
    localparam logic [3:0]  IDX_MSB    = 4'(BARKER_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Command word as carried on cmd_tdata: [18:8] mask, [7:0] frame count.
    typedef struct packed {
        logic [10:0] mask;
        logic [7:0]  count;
    } cmd_t;

    // One transmitted bit: Barker bit at idx, optionally corrupted by mask.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [10:0] mask);
        frame_bit = BARKER11[idx] ^ mask[idx];
    endfunction

endpackage

// File: rtl/barker_frame_tx_if.sv
// Bus bundle for barker_frame_tx.
//   cmd_tdata/cmd_tvalid/cmd_tready : command stream (count + mask)
//   m_tdata/m_tvalid/m_tlast/m_tready : 1-bit serial frame stream
//   o_busy/o_done                   : status
// Modport master is the transmitter side; slave is the environment side.
interface barker_frame_tx_if;

    logic [18:0] cmd_tdata;
    logic        cmd_tvalid;
    logic        cmd_tready;
    logic        m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        o_busy;
    logic        o_done;

    modport master (
        input  cmd_tdata,
        input  cmd_tvalid,
        output cmd_tready,
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        input  m_tready,
        output o_busy,
        output o_done
    );

    modport slave (
        output cmd_tdata,
        output cmd_tvalid,
        input  cmd_tready,
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        output m_tready,
        input  o_busy,
        input  o_done
    );

endinterface

// File: rtl/barker_frame_tx.sv
// Barker frame transmitter.
// Accepts a command (frame count N, XOR mask M) and serialises N copies of
// the 11-bit Barker sequence, MSB first, on a 1-bit stream with tlast on
// each frame's final bit. GAP_CYCLES idle cycles follow every frame except
// the last. o_done pulses once the last frame has been fully accepted.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : barker_frame_tx_if.master (command, stream and status signals)
module barker_frame_tx
    import barker_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    barker_frame_tx_if.master bus
);

    localparam logic [7:0] GAP_W = GAP_CYCLES[7:0];

    state_e      state_r,  state_s;
    logic [3:0]  idx_r,    idx_s;
    logic [8:0]  frames_r, frames_s;
    logic [7:0]  gap_r,    gap_s;
    logic [10:0] mask_r,   mask_s;

    logic        cmd_tready_r, cmd_tready_s;
    logic        m_tdata_r,    m_tdata_s;
    logic        m_tvalid_r,   m_tvalid_s;
    logic        m_tlast_r,    m_tlast_s;
    logic        busy_r,       busy_s;
    logic        done_r,       done_s;

    cmd_t        cmd_s;
    logic        beat_s;
    logic [8:0]  frames_left_s;

    // Next-state logic; outputs are derived from the next state so that the
    // registered outputs always describe the state being entered.
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        frames_s      = frames_r;
        gap_s         = gap_r;
        mask_s        = mask_r;
        cmd_s         = cmd_t'(bus.cmd_tdata);
        beat_s        = m_tvalid_r && bus.m_tready;
        frames_left_s = frames_r - 9'd1;

        case (state_r)
            ST_IDLE: begin
                // cmd_tready_r gates acceptance, so nothing is taken in the
                // first cycle after reset, before cmd_tready is visible.
                if (bus.cmd_tvalid && cmd_tready_r) begin
                    mask_s   = cmd_s.mask;
                    frames_s = {1'b0, cmd_s.count};
                    idx_s    = IDX_MSB;
                    if (cmd_s.count == 8'd0) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SEND;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (beat_s) begin
                    if (idx_r != 4'd0) begin
                        idx_s = idx_r - 4'd1;
                    end else begin
                        frames_s = frames_left_s;
                        if (frames_left_s == 9'd0) begin
                            state_s = ST_DONE;
                        end else if (GAP_W != 8'd0) begin
                            state_s = ST_GAP;
                            gap_s   = GAP_W - 8'd1;
                        end else begin
                            idx_s = IDX_MSB;
                        end
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_GAP: begin
                if (gap_r == 8'd0) begin
                    state_s = ST_SEND;
                    idx_s   = IDX_MSB;
                end else begin
                    gap_s = gap_r - 8'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        cmd_tready_s = (state_s == ST_IDLE);
        busy_s       = (state_s != ST_IDLE);
        done_s       = (state_s == ST_DONE);
        m_tvalid_s   = (state_s == ST_SEND);
        if (state_s == ST_SEND) begin
            m_tdata_s = frame_bit(idx_s, mask_s);
            m_tlast_s = (idx_s == 4'd0);
        end else begin
            m_tdata_s = 1'b0;
            m_tlast_s = 1'b0;
        end
    end

    // State, counters and registered outputs; reset aborts any frame at once.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= 4'd0;
            frames_r     <= 9'd0;
            gap_r        <= 8'd0;
            mask_r       <= 11'd0;
            cmd_tready_r <= 1'b0;
            m_tdata_r    <= 1'b0;
            m_tvalid_r   <= 1'b0;
            m_tlast_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            frames_r     <= frames_s;
            gap_r        <= gap_s;
            mask_r       <= mask_s;
            cmd_tready_r <= cmd_tready_s;
            m_tdata_r    <= m_tdata_s;
            m_tvalid_r   <= m_tvalid_s;
            m_tlast_r    <= m_tlast_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    assign bus.cmd_tready = cmd_tready_r;
    assign bus.m_tdata    = m_tdata_r;
    assign bus.m_tvalid   = m_tvalid_r;
    assign bus.m_tlast    = m_tlast_r;
    assign bus.o_busy     = busy_r;
    assign bus.o_done     = done_r;

endmodule

// File: tb/tb_barker_frame_tx.sv
// Scoreboard bench for barker_frame_tx: two instances (GAP_CYCLES 0 and 2)
// share the clock and reset; sel chooses which one is driven and watched.
module tb_barker_frame_tx;

    typedef struct packed {
        logic data;
        logic last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        cmd_tvalid = 1'b0;
    logic [18:0] cmd_tdata = 19'd0;
    logic        m_tready = 1'b1;
    logic        rand_rdy = 1'b0;

    // Hand-entered Barker-11 sequence, bit 10 sent first.
    logic [10:0] golden = 11'b11100010010;

    beat_t exp_q[$];
    beat_t mon_e;
    int    exp_done = 0;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    cur_gap = 0;
    int    acc_cyc = 0;
    int    exp_lat = 0;
    bit    lat_on = 1'b0;
    bit    has_beats = 1'b0;
    bit    done_seen = 1'b0;
    int    beats_seen = 0;
    int    tlast_cnt = 0;
    int    last_hs_cyc = 0;
    bit    after_last = 1'b0;
    int    gap_run = 0;
    bit    prev_stall = 1'b0;
    logic  prev_data = 1'b0;
    logic  prev_last = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    barker_frame_tx_if if0();
    barker_frame_tx_if if2();

    barker_frame_tx #(.GAP_CYCLES(0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0));
    barker_frame_tx #(.GAP_CYCLES(2)) dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(if2));

    assign if0.cmd_tvalid = cmd_tvalid & ~sel;
    assign if2.cmd_tvalid = cmd_tvalid & sel;
    assign if0.cmd_tdata  = cmd_tdata;
    assign if2.cmd_tdata  = cmd_tdata;
    assign if0.m_tready   = m_tready;
    assign if2.m_tready   = m_tready;

    logic s_cmd_tready, s_data, s_valid, s_last, s_busy, s_done;
    assign s_cmd_tready = sel ? if2.cmd_tready : if0.cmd_tready;
    assign s_data       = sel ? if2.m_tdata    : if0.m_tdata;
    assign s_valid      = sel ? if2.m_tvalid   : if0.m_tvalid;
    assign s_last       = sel ? if2.m_tlast    : if0.m_tlast;
    assign s_busy       = sel ? if2.o_busy     : if0.o_busy;
    assign s_done       = sel ? if2.o_done     : if0.o_done;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every handshake and every o_done pulse to the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_valid_hold", int'(s_valid), 1);
                chk("stall_data_hold", int'(s_data), int'(prev_data));
                chk("stall_last_hold", int'(s_last), int'(prev_last));
            end
            if (after_last) begin
                if (s_valid) begin
                    chk("gap_len", gap_run, cur_gap);
                    after_last = 1'b0;
                end else if (s_done) begin
                    after_last = 1'b0;
                end else begin
                    gap_run++;
                end
            end
            if (s_valid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", int'(s_data), int'(mon_e.data));
                    chk("beat_last", int'(s_last), int'(mon_e.last));
                end
                beats_seen++;
                if (s_last) begin
                    tlast_cnt++;
                    last_hs_cyc = cyc;
                    after_last = 1'b1;
                    gap_run = 0;
                end
            end
            prev_stall = s_valid && !m_tready;
            prev_data  = s_data;
            prev_last  = s_last;
            if (s_done) begin
                chk("done_expected", int'(exp_done > 0), 1);
                if (exp_done > 0) exp_done--;
                chk("done_queue_empty", exp_q.size(), 0);
                if (has_beats) chk("done_after_tlast", cyc - last_hs_cyc, 1);
                if (lat_on) chk("done_latency", cyc - acc_cyc, exp_lat);
                done_seen = 1'b1;
            end
        end else begin
            prev_stall = 1'b0;
            after_last = 1'b0;
        end
    end

    // Drives m_tready: fixed high, or random per cycle when rand_rdy is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_cmd(input int n, input logic [10:0] m, input bit lat);
        beat_t b;
        int    t;
        for (int f = 0; f < n; f++) begin
            for (int i = 10; i >= 0; i--) begin
                b.data = golden[i] ^ m[i];
                b.last = (i == 0);
                exp_q.push_back(b);
            end
        end
        exp_done++;
        cur_gap   = sel ? 2 : 0;
        has_beats = (n != 0);
        exp_lat   = (n > 0) ? (11 * n + cur_gap * (n - 1)) : 0;
        lat_on    = lat;
        t = 0;
        while (!s_cmd_tready && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("cmd_tready_wait", int'(s_cmd_tready), 1);
        done_seen  = 1'b0;
        cmd_tvalid = 1'b1;
        cmd_tdata  = {m, 8'(n)};
        @(posedge clk);
        #1;
        cmd_tvalid = 1'b0;
        acc_cyc    = cyc;
        chk("accept_tready_low", int'(s_cmd_tready), 0);
        chk("accept_valid", int'(s_valid), (n > 0) ? 1 : 0);
        if (n > 0) chk("first_bit", int'(s_data), int'(golden[10] ^ m[10]));
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (!done_seen && t < budget) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("done_timeout", int'(done_seen), 1);
        chk("tready_after_done", int'(s_cmd_tready), 1);
    endtask

    initial begin
        int base;
        int t;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_tready", int'(if0.cmd_tready), 0);
        chk("rst_m_tvalid", int'(if0.m_tvalid), 0);
        chk("rst_m_tdata", int'(if0.m_tdata), 0);
        chk("rst_m_tlast", int'(if0.m_tlast), 0);
        chk("rst_busy", int'(if0.o_busy), 0);
        chk("rst_done", int'(if0.o_done), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_cmd_tready", int'(if0.cmd_tready), 1);
        chk("idle_cmd_tready_g2", int'(if2.cmd_tready), 1);

        // Single clean frame
        sel = 1'b0;
        send_cmd(1, 11'h000, 1'b1);
        chk("busy_in_send", int'(s_busy), 1);
        wait_done(100);

        // Three frames with a 2-cycle gap
        sel = 1'b1;
        base = tlast_cnt;
        send_cmd(3, 11'h000, 1'b1);
        wait_done(200);
        chk("gap_tlast_count", tlast_cnt - base, 3);

        // Two back-to-back frames with bit 0 inverted
        sel = 1'b0;
        base = beats_seen;
        send_cmd(2, 11'h001, 1'b1);
        wait_done(200);
        chk("b2b_beats", beats_seen - base, 22);

        // Random backpressure
        rand_rdy = 1'b1;
        base = beats_seen;
        send_cmd(1, 11'h000, 1'b0);
        wait_done(1000);
        chk("stall_handshakes", beats_seen - base, 11);
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        // Zero frames: immediate done, no beats
        base = beats_seen;
        send_cmd(0, 11'h000, 1'b1);
        chk("n0_done", int'(s_done), 1);
        @(posedge clk);
        #1;
        chk("n0_done_low", int'(s_done), 0);
        chk("n0_cmd_tready", int'(s_cmd_tready), 1);
        chk("n0_no_beats", beats_seen - base, 0);

        // Reset in the middle of a four-frame command
        base = beats_seen;
        send_cmd(4, 11'h000, 1'b0);
        t = 0;
        while (beats_seen < base + 5 && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("reach_beat5", int'(beats_seen >= base + 5), 1);
        #1;
        rst_n = 1'b0;
        base = tlast_cnt;
        @(posedge clk);
        #1;
        chk("abort_valid", int'(s_valid), 0);
        chk("abort_data", int'(s_data), 0);
        chk("abort_last", int'(s_last), 0);
        chk("abort_busy", int'(s_busy), 0);
        chk("abort_tready", int'(s_cmd_tready), 0);
        exp_q.delete();
        exp_done = 0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_tlast", tlast_cnt - base, 0);
        send_cmd(1, 11'h000, 1'b1);
        wait_done(100);

        chk("end_queue_empty", exp_q.size(), 0);
        chk("end_done_balance", exp_done, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/barker_frame_tx.md
# barker_frame_tx

Transmit-side companion to the 11-bit Barker correlator. On a command it serialises a programmable number of 11-bit Barker frames (pattern 11'b11100010010) onto a 1-bit AXI-Stream, MSB first, with tlast on each frame's final bit. An optional per-command XOR mask corrupts the frames so the link and the correlator can be exercised with deliberate mismatches. It sits at the source end of the data path, or in loopback test harnesses driving the correlator's slave port.

## Interface
- GAP_CYCLES, default 0: idle cycles (m_tvalid low) inserted after each frame's last beat; range 0..255.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- cmd_tdata  in  19  [7:0] frame count N; [18:8] corruption mask M, XORed onto every frame of the command.
- cmd_tvalid  in  1  command valid.
- cmd_tready  out  1  block idle and able to accept a command.
- m_tdata  out  1  serial frame bit.
- m_tvalid  out  1  output beat valid.
- m_tlast  out  1  final (11th) bit of a frame.
- m_tready  in  1  downstream ready.
- o_busy  out  1  command in progress.
- o_done  out  1  one-cycle pulse: last frame of a command fully accepted.

## Operation
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE: cmd_tready=1. On cmd_tvalid&&cmd_tready, latch N and M, load bit index 10, frame counter N, go to SEND. If N=0, go directly to DONE and emit no beats.
- SEND: m_tvalid=1, m_tdata=BARKER11[idx]^M[idx], m_tlast=(idx==0). A beat advances only on m_tvalid&&m_tready; otherwise all m_* outputs hold stable.
- SEND, handshake with idx>0: idx decrements.
- SEND, handshake with idx==0: decrement frame counter.
  - If frames remain and GAP_CYCLES>0: go to GAP.
  - If frames remain and GAP_CYCLES=0: reload idx=10 and stay in SEND.
  - If no frames remain: go to DONE.
- GAP: m_tvalid=0 for exactly GAP_CYCLES cycles, then reload idx=10 and go to SEND.
- DONE: o_done=1 for one cycle, then IDLE.
- o_busy=1 in SEND, GAP and DONE.
- cmd_tvalid is ignored outside IDLE; no command queueing.
- Frame counter is 9 bits wide, so N=255 produces exactly 255 frames.

## Timing
- All outputs are registered. Reset values: cmd_tready=0, m_tdata=0, m_tvalid=0, m_tlast=0, o_busy=0, o_done=0.
- cmd_tready rises in the first cycle after i_rst_n deasserts.
- Command accepted at edge k: cmd_tready=0 and m_tvalid=1 with bit 10 from cycle k+1.
- With m_tready held high, one frame takes 11 cycles. Back-to-back frames (GAP_CYCLES=0) have no bubble.
- o_done asserts the cycle after the final tlast handshake. cmd_tready returns the cycle after that.
- m_tready low stalls indefinitely with no data change. m_tready has no effect in GAP.
- Reset asserted mid-frame: at the next edge, abort immediately, force outputs to reset values, and emit no partial tlast. After release the block is in IDLE.
- Simultaneous cmd_tvalid in the DONE cycle is not accepted (cmd_tready=0).

## Structure
- Package barker_pkg:
  - BARKER_LEN=11 and BARKER11=11'b11100010010, shared with the correlator so both ends use one definition.
  - Typedef for the state enum.
  - Packed struct for the command word: count[7:0], mask[10:0].
- Single module; no sub-module is natural. The 4-bit bit index, 9-bit frame counter and 8-bit gap counter are all inline.

## Test plan
- Reset release, then N=1, M=0, m_tready=1:
  - m_tdata sequence 1,1,1,0,0,0,1,0,0,1,0 over 11 cycles.
  - m_tlast only on the 11th beat.
  - o_done one cycle later.
  - Looped into the correlator, m_tuser=1.
- N=3, GAP_CYCLES=2:
  - 3 frames, each separated by exactly 2 cycles of m_tvalid=0.
  - 3 tlast beats, one o_done pulse, total 37 cycles from first beat to o_done.
- N=2, M=11'h001, GAP_CYCLES=0:
  - 22 contiguous beats; bit 0 of each frame inverted (final beat 1).
  - Correlator reports m_tuser=0 for both frames.
- N=1, random m_tready with ~50% duty:
  - m_tdata/m_tlast stable whenever m_tvalid&&!m_tready.
  - Exactly 11 handshakes, payload identical to the unstalled case.
- N=0: no m_tvalid assertion; o_done pulses the cycle after acceptance; cmd_tready high again the following cycle.
- Reset pulsed at beat 5 of N=4:
  - Outputs zero the following cycle; no tlast emitted.
  - New command N=1 then produces a clean single frame.
